key_repeat_bank: RTL and testbench
==================================

# key_repeat_bank

Parametrised, multi-channel successor to the single-button pulse conditioners (edge pulse, auto-shift, tap/hold sharing). It serves NUM_CH debounced button levels with a per-channel runtime mode: edge-only, auto-repeat (delay then rate), tap/hold, or disabled. It sits between the button debouncers and the game controller, and produces one-cycle action pulses.

## Interface
- NUM_CH, 8: number of independent channels.
- DELAY_CYCLES, 25245000: auto-repeat initial delay (170 ms at 148.5 MHz).
- RATE_CYCLES, 7425000: repeat period (50 ms).
- HOLD_CYCLES, 29700000: tap/hold threshold (200 ms).
- CNT_W, 29: per-channel counter width. Must satisfy 2^CNT_W > max(DELAY, RATE, HOLD).
- clk_in  input  1  system clock, single domain.
- reset_in  input  1  synchronous, active-high reset.
- level_in  input  NUM_CH  debounced button levels, synchronous to clk_in.
- mode_in  input  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 EDGE, 01 REPEAT, 10 TAP_HOLD, 11 OFF.
- press_pulse_out  output  NUM_CH  one-cycle action pulse (press, repeat, or tap).
- hold_pulse_out  output  NUM_CH  one-cycle hold pulse (TAP_HOLD mode only).
- busy_out  output  NUM_CH  channel is not IDLE.

## Operation
- Per channel:
  - Registered old_level. rise = level & ~old; held = level & old; fall = ~level & old.
- Mode is latched on rise. Changes to mode_in mid-press take effect at the next press.
- States:
  - IDLE: on rise with OFF, stay IDLE.
  - WAIT: counting delay or hold threshold.
  - RPT: counting repeat period.
- EDGE: rise gives a press pulse, and the channel stays IDLE. Nothing else.
- REPEAT:
  - rise: press pulse; go to WAIT with count = 0.
  - WAIT, held: count increments; at count == DELAY_CYCLES-1, press pulse, go to RPT, count = 0.
  - RPT, held: at count == RATE_CYCLES-1, press pulse, count = 0.
- TAP_HOLD:
  - rise: go to WAIT, no pulse.
  - fall in WAIT: press pulse (tap).
  - WAIT reaching HOLD_CYCLES-1: hold pulse, go to RPT.
  - RPT: hold pulse every RATE_CYCLES.
  - fall in RPT: no pulse.
- fall in any mode: go to IDLE, count = 0, no further pulses.
- Channels are fully independent, so simultaneous events on different channels all produce pulses in the same cycle.
- Counters never wrap. They are cleared on every state change and every RATE period.

## Timing
- Reset (synchronous, reset_in high at a clock edge):
  - press_pulse_out, hold_pulse_out, busy_out: 0.
  - state: IDLE; count: 0; latched mode: EDGE.
  - old_level loads level_in, so a key held through reset produces no pulse after reset deasserts.
- All outputs are registered. Taking the cycle where rise is true as cycle 0:
  - REPEAT pulses at cycles 1, 1+DELAY, 1+DELAY+k*RATE (k ≥ 1).
  - A TAP_HOLD hold pulse occurs at cycle 1+HOLD.
- Tap is detected at fall cycle f, with the pulse at f+1. Release on the same cycle the threshold is reached: fall wins, giving a tap and no hold.
- Each pulse is exactly one cycle wide. Pulses never overlap on one channel.
- reset_in mid-press aborts immediately with no pulse.
- busy_out = (state != IDLE), registered with the state.

## Structure
- Package key_repeat_pkg:
  - mode_t enum: EDGE, REPEAT, TAP_HOLD, OFF.
  - state_t enum: IDLE, WAIT, RPT.
- Sub-module key_repeat_channel: one FSM plus counter, parameterised by DELAY_CYCLES, RATE_CYCLES, HOLD_CYCLES, CNT_W.
  - The top instantiates NUM_CH copies in a generate loop and adds elaboration-time parameter assertions:
    - DELAY_CYCLES, RATE_CYCLES, HOLD_CYCLES ≥ 2.
    - All three fit in CNT_W.

## Test plan
Bench parameters: NUM_CH=4, DELAY=10, RATE=4, HOLD=6, CNT_W=5.
- Ch0 EDGE, hold high 30 cycles → exactly one press pulse, at cycle 1.
- Ch1 REPEAT, hold 25 cycles → press pulses at cycles 1, 11, 15, 19, 23. busy_out is 0 one cycle after release.
- Ch2 TAP_HOLD:
  - hold 3 cycles, release → one press pulse at release+1; no hold pulse.
  - hold 20 cycles → hold pulses at 7, 11, 15, 19; no press pulse on release.
- Ch3 OFF, toggle level → no pulses; busy_out stays 0. Switch mode_in to REPEAT mid-press → no pulses until the next rise.
- Reset pulse at cycle 12 during a REPEAT hold, key still held → all outputs 0 and no pulses afterwards until the key is released and pressed again.
- All four channels rise in the same cycle in REPEAT mode → identical pulse trains. Release ch1 at cycle 8 → only ch1 stops.

Source files
------------

// File: rtl/key_repeat_pkg.sv
// Shared types for the key repeat bank.
//   mode_t  : per-channel behaviour selected by mode_in (latched on press)
//   state_t : per-channel FSM state
package key_repeat_pkg;

  typedef enum logic [1:0] {
    EDGE     = 2'b00,
    REPEAT   = 2'b01,
    TAP_HOLD = 2'b10,
    OFF      = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RPT  = 2'b10
  } state_t;

endpackage

// File: rtl/key_repeat_channel.sv
// One button channel: edge detect, mode latch, FSM and shared counter.
//   clk_in          : system clock
//   reset_in        : synchronous active-high reset
//   level_in        : debounced button level
//   mode_in         : requested mode, sampled on the rising edge of level_in
//   press_pulse_out : one-cycle press / repeat / tap pulse
//   hold_pulse_out  : one-cycle hold pulse (TAP_HOLD only)
//   busy_out        : channel not IDLE
module key_repeat_channel
  import key_repeat_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = 25245000,
  parameter int unsigned RATE_CYCLES  = 7425000,
  parameter int unsigned HOLD_CYCLES  = 29700000,
  parameter int unsigned CNT_W        = 29
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       level_in,
  input  logic [1:0] mode_in,
  output logic       press_pulse_out,
  output logic       hold_pulse_out,
  output logic       busy_out
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_nxt;
  mode_t            mode, mode_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             old_level;
  logic             press_nxt, hold_nxt;
  logic             rise, held, fall;

  assign rise = level_in & ~old_level;
  assign held = level_in & old_level;
  assign fall = ~level_in & old_level;

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    count_nxt = count;
    press_nxt = 1'b0;
    hold_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          mode_nxt = mode_t'(mode_in);
          count_nxt = '0;
          case (mode_t'(mode_in))
            EDGE:     press_nxt = 1'b1;
            REPEAT: begin
              press_nxt = 1'b1;
              state_nxt = WAIT;
            end
            TAP_HOLD: state_nxt = WAIT;
            OFF:      ;
          endcase
        end
      end
      WAIT: begin
        // Release is checked first so a release on the threshold cycle is a tap.
        if (fall) begin
          state_nxt = IDLE;
          count_nxt = '0;
          press_nxt = (mode == TAP_HOLD);
        end else if (held) begin
          if (mode == REPEAT && count == DELAY_LAST) begin
            press_nxt = 1'b1;
            state_nxt = RPT;
            count_nxt = '0;
          end else if (mode == TAP_HOLD && count == HOLD_LAST) begin
            hold_nxt  = 1'b1;
            state_nxt = RPT;
            count_nxt = '0;
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end
      RPT: begin
        if (fall) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (held) begin
          if (count == RATE_LAST) begin
            press_nxt = (mode == REPEAT);
            hold_nxt  = (mode == TAP_HOLD);
            count_nxt = '0;
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      // Loading the live level suppresses a press for a key held through reset.
      old_level       <= level_in;
      state           <= IDLE;
      mode            <= EDGE;
      count           <= '0;
      press_pulse_out <= 1'b0;
      hold_pulse_out  <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      old_level       <= level_in;
      state           <= state_nxt;
      mode            <= mode_nxt;
      count           <= count_nxt;
      press_pulse_out <= press_nxt;
      hold_pulse_out  <= hold_nxt;
      busy_out        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: rtl/key_repeat_bank.sv
// Bank of NUM_CH independent key conditioners.
//   clk_in          : system clock
//   reset_in        : synchronous active-high reset
//   level_in        : [NUM_CH] debounced button levels
//   mode_in         : [2*NUM_CH] per-channel mode, bits [2i+1:2i]
//   press_pulse_out : [NUM_CH] press / repeat / tap pulses
//   hold_pulse_out  : [NUM_CH] hold pulses
//   busy_out        : [NUM_CH] channel not IDLE
module key_repeat_bank
  import key_repeat_pkg::*;
#(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned DELAY_CYCLES = 25245000,
  parameter int unsigned RATE_CYCLES  = 7425000,
  parameter int unsigned HOLD_CYCLES  = 29700000,
  parameter int unsigned CNT_W        = 29
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [NUM_CH-1:0]     level_in,
  input  logic [2*NUM_CH-1:0]   mode_in,
  output logic [NUM_CH-1:0]     press_pulse_out,
  output logic [NUM_CH-1:0]     hold_pulse_out,
  output logic [NUM_CH-1:0]     busy_out
);

  localparam longint CNT_LIMIT = longint'(1) << CNT_W;

  if (DELAY_CYCLES < 2 || RATE_CYCLES < 2 || HOLD_CYCLES < 2) begin : g_bad_min
    $error("key_repeat_bank: DELAY/RATE/HOLD_CYCLES must be >= 2");
  end

  if (longint'(DELAY_CYCLES) >= CNT_LIMIT || longint'(RATE_CYCLES) >= CNT_LIMIT ||
      longint'(HOLD_CYCLES) >= CNT_LIMIT) begin : g_bad_width
    $error("key_repeat_bank: CNT_W too narrow for DELAY/RATE/HOLD_CYCLES");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    key_repeat_channel #(
      .DELAY_CYCLES (DELAY_CYCLES),
      .RATE_CYCLES  (RATE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk_in          (clk_in),
      .reset_in        (reset_in),
      .level_in        (level_in[i]),
      .mode_in         (mode_in[2*i +: 2]),
      .press_pulse_out (press_pulse_out[i]),
      .hold_pulse_out  (hold_pulse_out[i]),
      .busy_out        (busy_out[i])
    );
  end

endmodule

// File: tb/tb_key_repeat_bank.sv
module tb_key_repeat_bank;

  localparam int NCH = 4;
  localparam int D   = 10;
  localparam int R   = 4;
  localparam int H   = 6;

  logic             clk = 1'b0;
  logic             reset_in = 1'b1;
  logic [NCH-1:0]   level_in = '0;
  logic [2*NCH-1:0] mode_in = '0;
  logic [NCH-1:0]   press_pulse_out, hold_pulse_out, busy_out;

  int vectors = 0;
  int errors  = 0;
  logic [3*NCH-1:0] sb[$];

  key_repeat_bank #(
    .NUM_CH       (NCH),
    .DELAY_CYCLES (D),
    .RATE_CYCLES  (R),
    .HOLD_CYCLES  (H),
    .CNT_W        (5)
  ) dut (
    .clk_in          (clk),
    .reset_in        (reset_in),
    .level_in        (level_in),
    .mode_in         (mode_in),
    .press_pulse_out (press_pulse_out),
    .hold_pulse_out  (hold_pulse_out),
    .busy_out        (busy_out)
  );

  always #5 clk = ~clk;

  // Expected {press, hold, busy} of one channel at cycle s (rise edge = cycle 0),
  // key held for len edges, optional reset at edge rstc.
  function automatic logic [2:0] exp_ch(input logic [1:0] m, input int len,
                                        input int rstc, input int s);
    logic p, h, b;
    p = 1'b0; h = 1'b0; b = 1'b0;
    if (len > 0 && !(rstc >= 0 && s > rstc)) begin
      case (m)
        2'b00: p = (s == 1);
        2'b01: begin
          b = (s <= len);
          p = (s <= len) && (s == 1 || (s >= 1 + D && ((s - 1 - D) % R) == 0));
        end
        2'b10: begin
          b = (s <= len);
          if (len <= H) p = (s == len + 1);
          else h = (s >= 1 + H) && (s <= len) && (((s - 1 - H) % R) == 0);
        end
        default: ;
      endcase
    end
    return {p, h, b};
  endfunction

  function automatic logic [3*NCH-1:0] exp_vec(input logic [2*NCH-1:0] md, input int len[NCH],
                                               input int rstc, input int s);
    logic [NCH-1:0] p, h, b;
    logic [2:0] e;
    for (int c = 0; c < NCH; c++) begin
      e = exp_ch(md[2*c +: 2], len[c], rstc, s);
      p[c] = e[2]; h[c] = e[1]; b[c] = e[0];
    end
    return {p, h, b};
  endfunction

  function automatic logic [NCH-1:0] lvl_at(input int len[NCH], input int t);
    logic [NCH-1:0] l;
    for (int c = 0; c < NCH; c++) l[c] = (t < len[c]);
    return l;
  endfunction

  // Drives one clock edge worth of stimulus and queues what should follow it.
  task automatic apply_cycle(input logic [NCH-1:0] lv, input logic [2*NCH-1:0] md,
                             input logic rst, input logic [3*NCH-1:0] expv);
    level_in = lv;
    mode_in  = md;
    reset_in = rst;
    sb.push_back(expv);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3*NCH-1:0] got, expv;
    for (int t = 0; t < 10; t++) begin
      apply_cycle((t < 7) ? 4'b1111 : 4'b0000, 8'h00, (t < 2), '0);
      got = {press_pulse_out, hold_pulse_out, busy_out};
      expv = sb.pop_front();
      vectors++;
      if (got !== expv) begin
        errors++;
        $display("FAIL reset t=%0d got=%h exp=%h", t, got, expv);
      end
    end
  endtask

  task automatic run_case(input string name, input logic [2*NCH-1:0] md,
                          input int len[NCH], input int rstc, input int cycles);
    logic [3*NCH-1:0] got, expv;
    for (int t = 0; t < cycles; t++) begin
      apply_cycle(lvl_at(len, t), md, (t == rstc), exp_vec(md, len, rstc, t + 1));
      got = {press_pulse_out, hold_pulse_out, busy_out};
      expv = sb.pop_front();
      vectors++;
      if (got !== expv) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", name, t + 1, got, expv);
      end
    end
  endtask

  task automatic test_edge();
    run_case("edge", 8'b00_00_00_00, '{30, 0, 0, 0}, -1, 34);
  endtask

  task automatic test_repeat();
    run_case("repeat", 8'b00_00_01_00, '{0, 25, 0, 0}, -1, 28);
  endtask

  task automatic test_tap_hold();
    run_case("tap3",  8'b00_10_00_00, '{0, 0, 3, 0},  -1, 6);
    run_case("tap6",  8'b00_10_00_00, '{0, 0, 6, 0},  -1, 9);
    run_case("hold7", 8'b00_10_00_00, '{0, 0, 7, 0},  -1, 10);
    run_case("hold20", 8'b00_10_00_00, '{0, 0, 20, 0}, -1, 23);
  endtask

  task automatic test_off_mode_change();
    logic [3*NCH-1:0] got, expv;
    run_case("off", 8'b11_00_00_00, '{0, 0, 0, 4}, -1, 6);
    // Mode request changes to REPEAT while the OFF press is still held.
    for (int t = 0; t < 14; t++) begin
      apply_cycle({(t < 10), 3'b000}, (t < 3) ? 8'b11_00_00_00 : 8'b01_00_00_00, 1'b0, '0);
      got = {press_pulse_out, hold_pulse_out, busy_out};
      expv = sb.pop_front();
      vectors++;
      if (got !== expv) begin
        errors++;
        $display("FAIL off_midpress t=%0d got=%h exp=%h", t, got, expv);
      end
    end
    run_case("off_next_press", 8'b01_00_00_00, '{0, 0, 0, 12}, -1, 15);
  endtask

  task automatic test_reset_midpress();
    run_case("reset_mid", 8'b00_00_01_00, '{0, 20, 0, 0}, 12, 23);
    run_case("after_reset", 8'b00_00_01_00, '{0, 2, 0, 0}, -1, 5);
  endtask

  task automatic test_back_to_back();
    run_case("all_repeat", 8'b01_01_01_01, '{20, 8, 20, 20}, -1, 23);
  endtask

  initial begin
    test_reset();
    test_edge();
    test_repeat();
    test_tap_hold();
    test_off_mode_change();
    test_reset_midpress();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
